fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/pc_pkg.sv | 15 +
 rtl/ras_stack.sv | 51 +++++
 rtl/fetch_pc_gen.sv | 75 +++++++
 tb/tb_fetch_pc_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared address width, default vectors and next-PC select encoding.
package pc_pkg;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DEF_RESET_VECTOR = 32'h0000_3000;
    localparam logic [ADDR_W-1:0] DEF_EXC_VECTOR = 32'hBFC0_0380;
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_JREG,
        SEL_JIMM,
        SEL_BRANCH,
        SEL_ERET,
        SEL_EXC
    } nextSel_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating count; overwrites oldest entry when full.
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] top,
    output logic             valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] topPtr;
    logic [PW-1:0] nxtPtr;
    logic [CW-1:0] count;
    logic empty, full, doPush, doRepl, doPop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign nxtPtr = topPtr + 1'b1;
    // push+pop on an empty stack degenerates into a plain push
    assign doPush = push && !(pop && !empty);
    assign doRepl = push && pop && !empty;
    assign doPop = pop && !push && !empty;
    assign top = mem[topPtr];
    assign valid = !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            topPtr <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (doPush) begin
            topPtr <= nxtPtr;
            count <= full ? count : count + 1'b1;
        end else if (doPop) begin
            topPtr <= topPtr - 1'b1;
            count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (doPush) mem[nxtPtr] <= data;
            else if (doRepl) mem[topPtr] <= data;
        end
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch program counter with prioritised redirects and a return-address stack.
module fetch_pc_gen
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic        take_exception,
    input  logic        take_eret,
    input  logic        take_branch,
    input  logic        take_jump_imm,
    input  logic        take_jump_reg,
    input  logic [31:0] epc,
    input  logic [31:0] branch_imm_ex,
    input  logic [25:0] jump_imm,
    input  logic [31:0] jump_reg,
    output logic        addr_err,
    input  logic        ras_push,
    input  logic        ras_pop,
    input  logic        ras_flush,
    input  logic [31:0] link_addr,
    output logic [31:0] ras_top,
    output logic        ras_valid
);
    nextSel_t sel;
    logic [ADDR_W-1:0] nextPc;
    logic accept;
    assign fetch_valid = !rst;
    assign pc4 = pc + 32'd4;
    assign accept = fetch_valid && fetch_ready && !stall;
    always_comb begin
        sel = take_exception ? SEL_EXC :
              take_eret      ? SEL_ERET :
              take_branch    ? SEL_BRANCH :
              take_jump_imm  ? SEL_JIMM :
              take_jump_reg  ? SEL_JREG :
              accept         ? SEL_SEQ : SEL_HOLD;
        nextPc = sel == SEL_EXC    ? EXC_VECTOR :
                 sel == SEL_ERET   ? epc :
                 sel == SEL_BRANCH ? pc4 + (branch_imm_ex << 2) :
                 sel == SEL_JIMM   ? {pc4[31:28], jump_imm, 2'b00} :
                 sel == SEL_JREG   ? {jump_reg[31:2], 2'b00} :
                 sel == SEL_SEQ    ? pc4 : pc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
            addr_err <= 1'b0;
        end else begin
            pc <= nextPc;
            addr_err <= sel == SEL_JREG && jump_reg[1:0] != 2'b00;
        end
    end
    ras_stack #(
        .DEPTH(RAS_DEPTH),
        .WIDTH(ADDR_W)
    ) uRas (
        .clk(clk),
        .rst(rst),
        .push(ras_push),
        .pop(ras_pop),
        .flush(ras_flush || take_exception),
        .data(link_addr),
        .top(ras_top),
        .valid(ras_valid)
    );
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed self-checking bench for fetch_pc_gen.
module tb_fetch_pc_gen;
    logic clk = 1'b0;
    logic rst, stall, fetchValid, fetchReady, addrErr;
    logic [31:0] pc, pc4, epc, branchImm, jumpReg, linkAddr, rasTop;
    logic [25:0] jumpImm;
    logic takeExc, takeEret, takeBranch, takeJimm, takeJreg;
    logic rasPush, rasPop, rasFlush, rasValid;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    fetch_pc_gen dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_valid(fetchValid),
        .fetch_ready(fetchReady), .pc(pc), .pc4(pc4),
        .take_exception(takeExc), .take_eret(takeEret), .take_branch(takeBranch),
        .take_jump_imm(takeJimm), .take_jump_reg(takeJreg),
        .epc(epc), .branch_imm_ex(branchImm), .jump_imm(jumpImm), .jump_reg(jumpReg),
        .addr_err(addrErr), .ras_push(rasPush), .ras_pop(rasPop), .ras_flush(rasFlush),
        .link_addr(linkAddr), .ras_top(rasTop), .ras_valid(rasValid)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clearRedirects();
        {takeExc, takeEret, takeBranch, takeJimm, takeJreg} = '0;
    endtask
    initial begin
        rst = 1'b1; stall = 1'b0; fetchReady = 1'b0;
        clearRedirects();
        epc = '0; branchImm = '0; jumpImm = '0; jumpReg = '0; linkAddr = '0;
        {rasPush, rasPop, rasFlush} = '0;
        #1;
        check("fv_in_rst", 32'(fetchValid), 32'd0);
        tick();
        check("pc_reset", pc, 32'h3000);
        check("pc4_reset", pc4, 32'h3004);
        check("ras_valid_reset", 32'(rasValid), 32'd0);
        check("addr_err_reset", 32'(addrErr), 32'd0);
        rst = 1'b0;
        #1;
        check("fv_after_rst", 32'(fetchValid), 32'd1);
        fetchReady = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("pc_seq", pc, 32'h3000 + 32'(4 * i));
        end
        fetchReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("pc_not_ready", pc, 32'h300C);
            check("fv_not_ready", 32'(fetchValid), 32'd1);
        end
        stall = 1'b1; fetchReady = 1'b1;
        tick();
        check("pc_stall", pc, 32'h300C);
        check("fv_stall", 32'(fetchValid), 32'd1);
        stall = 1'b0;
        tick();
        check("pc_after_stall", pc, 32'h3010);
        fetchReady = 1'b0;
        rasPush = 1'b1; linkAddr = 32'h700;
        tick();
        rasPush = 1'b0;
        check("ras_pre_exc_valid", 32'(rasValid), 32'd1);
        check("ras_pre_exc_top", rasTop, 32'h700);
        takeExc = 1'b1; takeBranch = 1'b1; takeJimm = 1'b1; branchImm = 32'd5; jumpImm = 26'h123;
        tick();
        clearRedirects();
        check("pc_exc_priority", pc, 32'hBFC0_0380);
        check("ras_flushed_by_exc", 32'(rasValid), 32'd0);
        takeEret = 1'b1; takeBranch = 1'b1; epc = 32'h3010;
        tick();
        clearRedirects();
        check("pc_eret_priority", pc, 32'h3010);
        takeBranch = 1'b1; takeJimm = 1'b1; branchImm = 32'hFFFF_FFFF;
        tick();
        clearRedirects();
        check("pc_branch_neg", pc, 32'h3010);
        takeJimm = 1'b1; jumpImm = 26'h100;
        tick();
        clearRedirects();
        check("pc_jump_imm", pc, 32'h0000_0400);
        takeJreg = 1'b1; jumpReg = 32'h0000_4006;
        tick();
        clearRedirects();
        check("pc_jump_reg", pc, 32'h4004);
        check("addr_err_pulse", 32'(addrErr), 32'd1);
        tick();
        check("addr_err_clear", 32'(addrErr), 32'd0);
        check("pc_hold_after_jr", pc, 32'h4004);
        takeJreg = 1'b1; jumpReg = 32'hFFFF_FFFC;
        tick();
        clearRedirects();
        check("pc_jr_aligned", pc, 32'hFFFF_FFFC);
        check("addr_err_aligned", 32'(addrErr), 32'd0);
        fetchReady = 1'b1;
        tick();
        check("pc_wrap", pc, 32'h0);
        fetchReady = 1'b0;
        rasPush = 1'b1;
        for (int i = 0; i < 10; i++) begin
            linkAddr = 32'h100 + 32'(4 * i);
            tick();
        end
        rasPush = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) begin
                check("ras_pop_top", rasTop, 32'h124 - 32'(4 * k));
                check("ras_pop_valid", 32'(rasValid), 32'd1);
            end
            rasPop = 1'b1;
            tick();
            rasPop = 1'b0;
            if (k >= 7) check("ras_empty", 32'(rasValid), 32'd0);
        end
        rasPush = 1'b1; linkAddr = 32'h600;
        tick();
        rasPush = 1'b0;
        check("ras_push_after_underflow", rasTop, 32'h600);
        rasPop = 1'b1;
        tick();
        rasPop = 1'b0;
        check("ras_single_pop", 32'(rasValid), 32'd0);
        rasPush = 1'b1; rasPop = 1'b1; linkAddr = 32'h500;
        tick();
        check("ras_pp_empty_valid", 32'(rasValid), 32'd1);
        check("ras_pp_empty_top", rasTop, 32'h500);
        linkAddr = 32'h504;
        tick();
        check("ras_pp_replace_top", rasTop, 32'h504);
        rasPush = 1'b0;
        tick();
        check("ras_pp_count_kept", 32'(rasValid), 32'd0);
        rasPush = 1'b1; rasPop = 1'b0; rasFlush = 1'b1;
        tick();
        {rasPush, rasFlush} = '0;
        check("ras_push_flush", 32'(rasValid), 32'd0);
        rasPush = 1'b1; linkAddr = 32'h800;
        tick();
        rasPush = 1'b0;
        rst = 1'b1; takeExc = 1'b1; takeJreg = 1'b1; jumpReg = 32'h3; fetchReady = 1'b1;
        #1;
        check("fv_rst_again", 32'(fetchValid), 32'd0);
        tick();
        clearRedirects();
        check("pc_rst_override", pc, 32'h3000);
        check("addr_err_rst_override", 32'(addrErr), 32'd0);
        check("ras_rst", 32'(rasValid), 32'd0);
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
